adder_arbiter: RTL

Shares one 32-bit combinational adder (a + b + cin → sum, cout) among NREQ requesters. Arbitrates round-robin, registers the winner's operands, holds them for ADD_CYCLES so the long carry chain settles as a multicycle path, then returns the registered result to the winner over a valid/ready response channel. Sits between the issuing units and the shared adder datapath and is the only block that drives the adder's inputs.

---
 rtl/adder_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/adder_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin shared-adder arbiter.
package adder_arb_pkg;
  localparam int ADD_WIDTH = 32;
  localparam int MAX_NREQ  = 8;
  localparam int IDX_W     = $clog2(MAX_NREQ);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output logic [NREQ-1:0] grant,
  output idx_t            idx
);

  logic found;

  // Offset 1..NREQ so the previous winner (ptr) is considered last.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[k] && (k == ((int'(ptr) + off) % NREQ))) begin
          grant[k] = 1'b1;
          idx      = idx_t'(k);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Time-shares one 32-bit adder among NREQ requesters with a multicycle settle window.
// Optional signed-overflow output enabled by defining ADDER_ARB_OVF_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WIDTH      = ADD_WIDTH,
  parameter int ADD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
`ifdef ADDER_ARB_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic                  busy,
  output state_e                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; req_ready is a one-hot grant, rsp_valid is one-hot to the owner.

  localparam int CNT_W = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  state_e             state_q, state_d;
  idx_t               ptr_q, ptr_d;
  idx_t               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef ADDER_ARB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NREQ-1:0]    grant;
  idx_t               grant_idx;
  logic [NREQ-1:0]    owner_oh;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [WIDTH:0]     add_res;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  // The adder sees only the operand registers, so it is a clean multicycle path.
  assign add_res  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_ARB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          a_d     = a_sel;
          b_d     = b_sel;
          cin_d   = |(req_cin & grant);
          owner_d = grant_idx;
          cnt_d   = CNT_W'(ADD_CYCLES - 1);
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt_q == '0) begin
          sum_d   = add_res[WIDTH-1:0];
          cout_d  = add_res[WIDTH];
`ifdef ADDER_ARB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
`endif
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        if (|(rsp_ready & owner_oh)) begin
          ptr_d   = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= idx_t'(NREQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_ARB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE)    ? grant    : '0;
  assign rsp_valid = (state_q == RESPOND) ? owner_oh : '0;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
`ifdef ADDER_ARB_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
